// File: rtl/memoria_instrucoes_carregavel_pkg.sv
// Shared processor constants: NOP word, instruction opcodes and the
// state encoding of the program loader.
package proc_pkg;

   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   localparam logic [4:0] OP_NOTHING = 5'd0;
   localparam logic [4:0] OP_INPUT   = 5'd1;
   localparam logic [4:0] OP_OUTPUT  = 5'd2;
   localparam logic [4:0] OP_BRANCHI = 5'd3;
   localparam logic [4:0] OP_JUMP    = 5'd4;
   localparam logic [4:0] OP_EQ      = 5'd5;
   localparam logic [4:0] OP_STOP    = 5'd6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } loader_state_e;

endpackage

// File: rtl/memoria_instrucoes_carregavel_if.sv
// Fetch and program-load signals of the loadable instruction memory.
// slave is the memory side, master is the core/loader side.
interface memoria_instrucoes_carregavel_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
);
   logic [ADDR_WIDTH-1:0] pc_counter;
   logic                  fetch_en;
   logic [DATA_WIDTH-1:0] instruction;
   logic                  instr_valid;
   logic                  load_start;
   logic [ADDR_WIDTH:0]   load_len;
   logic [7:0]            load_data;
   logic                  load_valid;
   logic                  load_ready;
   logic                  busy;
   logic                  load_done;
   logic                  load_error;
   logic [ADDR_WIDTH:0]   word_count;

   modport slave (
      input  pc_counter, fetch_en, load_start, load_len, load_data, load_valid,
      output instruction, instr_valid, load_ready, busy, load_done, load_error, word_count
   );

   modport master (
      output pc_counter, fetch_en, load_start, load_len, load_data, load_valid,
      input  instruction, instr_valid, load_ready, busy, load_done, load_error, word_count
   );
endinterface

// File: rtl/memoria_instrucoes_carregavel_ram.sv
// DEPTH x DATA_WIDTH storage with one synchronous read and one synchronous
// write port. No reset: contents persist across core resets.
module ram_1r1w_sync #(
   parameter int DEPTH      = 1024,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clock,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // write port
   always_ff @(posedge clock) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // read port; rdata holds while re_i is low
   always_ff @(posedge clock) begin
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/memoria_instrucoes_carregavel.sv
// Run-time loadable instruction memory: a byte-stream loader FSM packs
// MSB-first bytes into words, and a registered fetch port gated while loading.
module memoria_instrucoes_carregavel #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 10,
   parameter int                    DEPTH      = 1024,
   parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(proc_pkg::NOP_WORD)
) (
   input logic                        clock,
   input logic                        reset_n,
   memoria_instrucoes_carregavel_if.slave bus
);
   import proc_pkg::*;

   localparam int                  BYTES     = DATA_WIDTH / 8;
   localparam int                  BCW       = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [BCW-1:0]      LAST_BYTE = BCW'(BYTES - 1);
   localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

   loader_state_e         state_q, state_d;
   logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d;
   logic [ADDR_WIDTH:0]   len_q, len_d;
   logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
   logic                  load_error_d;
   logic                  load_ready_q, busy_q, load_done_q, load_error_q;
   logic                  instr_valid_q;
   logic                  byte_acc_s, mem_we_s, fetch_ok_s, rd_en_s;
   logic [DATA_WIDTH-1:0] rd_data_s;

   assign byte_acc_s = (state_q == ST_RECV) && bus.load_valid;

   // loader next-state: request checks, byte packing, word write sequencing
   always_comb begin
      state_d      = state_q;
      byte_cnt_d   = byte_cnt_q;
      acc_d        = acc_q;
      len_d        = len_q;
      word_count_d = word_count_q;
      load_error_d = 1'b0;
      mem_we_s     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.load_start) begin
               if (bus.load_len == '0) begin
                  word_count_d = '0;
                  state_d      = ST_DONE;
               end else if (bus.load_len > DEPTH_W) begin
                  load_error_d = 1'b1;
               end else begin
                  word_count_d = '0;
                  byte_cnt_d   = '0;
                  len_d        = bus.load_len;
                  state_d      = ST_RECV;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RECV: begin
            if (byte_acc_s) begin
               acc_d      = (acc_q << 8) | DATA_WIDTH'(bus.load_data);
               byte_cnt_d = byte_cnt_q + BCW'(1);
               if (byte_cnt_q == LAST_BYTE) begin
                  byte_cnt_d = '0;
                  state_d    = ST_WRITE;
               end else begin
                  state_d = ST_RECV;
               end
            end else begin
               state_d = ST_RECV;
            end
         end
         ST_WRITE: begin
            mem_we_s     = 1'b1;
            word_count_d = word_count_q + (ADDR_WIDTH + 1)'(1);
            if (word_count_d == len_q) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_RECV;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // loader state and status outputs, registered from the next state
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         byte_cnt_q   <= '0;
         acc_q        <= '0;
         len_q        <= '0;
         word_count_q <= '0;
         load_ready_q <= 1'b0;
         busy_q       <= 1'b0;
         load_done_q  <= 1'b0;
         load_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         acc_q        <= acc_d;
         len_q        <= len_d;
         word_count_q <= word_count_d;
         load_ready_q <= (state_d == ST_RECV);
         busy_q       <= (state_d != ST_IDLE);
         load_done_q  <= (state_d == ST_DONE);
         load_error_q <= load_error_d;
      end
   end

   // busy_q mirrors state_q != IDLE, so a fetch alongside load_start is still served
   assign fetch_ok_s = !busy_q && ({1'b0, bus.pc_counter} < DEPTH_W);
   assign rd_en_s    = bus.fetch_en && fetch_ok_s;

   // fetch validity; holds while fetch_en is low
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         instr_valid_q <= 1'b0;
      end else if (bus.fetch_en) begin
         instr_valid_q <= fetch_ok_s;
      end
   end

   ram_1r1w_sync #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clock   (clock),
      .we_i    (mem_we_s),
      .waddr_i (word_count_q[ADDR_WIDTH-1:0]),
      .wdata_i (acc_q),
      .re_i    (rd_en_s),
      .raddr_i (bus.pc_counter),
      .rdata_o (rd_data_s)
   );

   assign bus.instruction = instr_valid_q ? rd_data_s : NOP_WORD;
   assign bus.instr_valid = instr_valid_q;
   assign bus.load_ready  = load_ready_q;
   assign bus.busy        = busy_q;
   assign bus.load_done   = load_done_q;
   assign bus.load_error  = load_error_q;
   assign bus.word_count  = word_count_q;

endmodule

// File: tb/tb_memoria_instrucoes_carregavel.sv
// Randomised bench for the loadable instruction memory; expected fetch data
// comes from a word-array model filled from the bytes the bench streams.
module tb_memoria_instrucoes_carregavel;
   localparam int             DW    = 32;
   localparam int             AW    = 10;
   localparam int             DEPTH = 1024;
   localparam logic [DW-1:0]  NOP   = 32'h0000_0000;

   logic clock;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   logic [DW-1:0] model_mem   [DEPTH];
   bit            model_known [DEPTH];
   int            acc_cyc     [$];

   memoria_instrucoes_carregavel_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   memoria_instrucoes_carregavel #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .DEPTH      (DEPTH),
      .NOP_WORD   (NOP)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_blocked(input string tag);
      check_eq({tag, "_iv"}, 64'(bus.instr_valid), 64'd0);
      check_eq({tag, "_ins"}, 64'(bus.instruction), 64'(NOP));
   endtask

   task automatic fetch_chk(input int pc, input string tag);
      @(negedge clock);
      bus.pc_counter = AW'(pc);
      bus.fetch_en   = 1'b1;
      @(negedge clock);
      bus.fetch_en   = 1'b0;
      if (model_known[pc]) begin
         check_eq({tag, "_iv"}, 64'(bus.instr_valid), 64'd1);
         check_eq({tag, "_ins"}, 64'(bus.instruction), 64'(model_mem[pc]));
      end
   endtask

   task automatic start_load(input int len);
      @(negedge clock);
      bus.load_start = 1'b1;
      bus.load_len   = (AW + 1)'(len);
      @(negedge clock);
      bus.load_start = 1'b0;
      bus.load_len   = '0;
   endtask

   // streams nbytes MSB-first; returns at the negedge after the last accepting edge
   task automatic send_bytes(input logic [DW-1:0] words[$], input int nbytes,
                             input int gap_min, input int gap_max, input bit chk_fetch);
      bit armed = 1'b0;
      int tries;
      acc_cyc.delete();
      for (int i = 0; i < nbytes; i++) begin
         logic [DW-1:0] w;
         int            gap;
         w   = words[i / 4];
         gap = $urandom_range(gap_max, gap_min);
         for (int g = 0; g < gap; g++) begin
            bus.load_valid = 1'b0;
            if (chk_fetch && armed) check_blocked("ld_blk");
            armed = 1'b1;
            @(negedge clock);
         end
         bus.load_valid = 1'b1;
         bus.load_data  = w[DW-1-8*(i%4) -: 8];
         tries = 0;
         while (!bus.load_ready && tries < 16) begin
            if (chk_fetch && armed) check_blocked("ld_blk");
            armed = 1'b1;
            @(negedge clock);
            tries++;
         end
         if (tries >= 16) begin
            check_eq("ready_timeout", 64'd0, 64'd1);
            bus.load_valid = 1'b0;
            return;
         end
         if (chk_fetch && armed) check_blocked("ld_blk");
         armed = 1'b1;
         acc_cyc.push_back(cyc);
         @(negedge clock);
      end
      bus.load_valid = 1'b0;
   endtask

   // WRITE cycle, then the DONE pulse, then IDLE; optional fetch of pc 0 held high
   task automatic finish_load(input int len, input bit chk_fetch);
      if (chk_fetch) check_blocked("fin_blk");
      check_eq("done_early", 64'(bus.load_done), 64'd0);
      @(negedge clock);
      check_eq("done_pulse", 64'(bus.load_done), 64'd1);
      check_eq("done_wc", 64'(bus.word_count), 64'(len));
      check_eq("done_busy", 64'(bus.busy), 64'd1);
      if (chk_fetch) check_blocked("fin_blk");
      @(negedge clock);
      check_eq("done_end", 64'(bus.load_done), 64'd0);
      check_eq("idle_busy", 64'(bus.busy), 64'd0);
      if (chk_fetch) begin
         check_blocked("fin_blk");
         @(negedge clock);
         check_eq("post_iv", 64'(bus.instr_valid), 64'd1);
         check_eq("post_ins", 64'(bus.instruction), 64'(model_mem[0]));
         bus.fetch_en = 1'b0;
      end
   endtask

   initial begin
      logic [DW-1:0] words[$];
      logic [DW-1:0] held;
      int            len;
      int            pc;

      reset_n        = 1'b0;
      bus.pc_counter = '0;
      bus.fetch_en   = 1'b0;
      bus.load_start = 1'b0;
      bus.load_len   = '0;
      bus.load_data  = '0;
      bus.load_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) model_known[i] = 1'b0;

      // reset state
      repeat (3) @(negedge clock);
      check_eq("rst_ins", 64'(bus.instruction), 64'(NOP));
      check_eq("rst_iv", 64'(bus.instr_valid), 64'd0);
      check_eq("rst_ready", 64'(bus.load_ready), 64'd0);
      check_eq("rst_busy", 64'(bus.busy), 64'd0);
      check_eq("rst_done", 64'(bus.load_done), 64'd0);
      check_eq("rst_err", 64'(bus.load_error), 64'd0);
      check_eq("rst_wc", 64'(bus.word_count), 64'd0);
      reset_n = 1'b1;
      @(negedge clock);

      // directed two-word load, back-to-back bytes, fetch of pc 0 held during it
      words = '{32'h3800_0000, 32'h4000_0000};
      bus.pc_counter = '0;
      bus.fetch_en   = 1'b1;
      start_load(2);
      check_eq("t2_busy", 64'(bus.busy), 64'd1);
      send_bytes(words, 8, 0, 0, 1'b1);
      check_eq("t2_word1_span", 64'(acc_cyc[3] - acc_cyc[0]), 64'd3);
      check_eq("t2_bubble", 64'(acc_cyc[4] - acc_cyc[3]), 64'd2);
      check_eq("t2_word2_span", 64'(acc_cyc[7] - acc_cyc[4]), 64'd3);
      check_eq("t2_ready_drop", 64'(bus.load_ready), 64'd0);
      model_mem[0] = 32'h3800_0000; model_known[0] = 1'b1;
      model_mem[1] = 32'h4000_0000; model_known[1] = 1'b1;
      finish_load(2, 1'b1);
      fetch_chk(1, "t2_pc1");
      check_eq("t2_pc1_lit", 64'(bus.instruction), 64'h4000_0000);

      // oversize request rejected
      start_load(DEPTH + 1);
      check_eq("err_pulse", 64'(bus.load_error), 64'd1);
      check_eq("err_busy", 64'(bus.busy), 64'd0);
      check_eq("err_ready", 64'(bus.load_ready), 64'd0);
      @(negedge clock);
      check_eq("err_end", 64'(bus.load_error), 64'd0);
      check_eq("err_wc", 64'(bus.word_count), 64'd2);
      fetch_chk(0, "err_pc0");
      fetch_chk(1, "err_pc1");

      // zero-length load
      start_load(0);
      check_eq("z_done", 64'(bus.load_done), 64'd1);
      check_eq("z_busy", 64'(bus.busy), 64'd1);
      check_eq("z_wc", 64'(bus.word_count), 64'd0);
      @(negedge clock);
      check_eq("z_done_end", 64'(bus.load_done), 64'd0);
      check_eq("z_idle", 64'(bus.busy), 64'd0);

      // randomised loads with gapped bytes, then random fetches and hold checks
      for (int l = 0; l < 5; l++) begin
         len = $urandom_range(8, 1);
         words.delete();
         for (int w = 0; w < len; w++) words.push_back($urandom);
         @(negedge clock);
         bus.pc_counter = '0;
         bus.fetch_en   = 1'b1;
         start_load(len);
         check_eq("rl_served_iv", 64'(bus.instr_valid), 64'd1);
         check_eq("rl_served_ins", 64'(bus.instruction), 64'(model_mem[0]));
         send_bytes(words, len * 4, 0, 2, 1'b1);
         for (int w = 0; w < len; w++) begin
            model_mem[w]   = words[w];
            model_known[w] = 1'b1;
         end
         finish_load(len, 1'b1);
         for (int f = 0; f < 4; f++) begin
            pc = $urandom_range(9, 0);
            fetch_chk(pc, "rl_fetch");
            held = bus.instruction;
            bus.pc_counter = AW'((pc + 1) % 10);
            @(negedge clock);
            check_eq("rl_hold", 64'(bus.instruction), 64'(held));
         end
      end

      // reset after the 6th byte of a 3-word load, one byte every 3 cycles
      words.delete();
      words.push_back(~model_mem[0]);
      words.push_back(~model_mem[1]);
      words.push_back($urandom);
      start_load(3);
      send_bytes(words, 6, 2, 2, 1'b0);
      model_mem[0] = words[0];
      reset_n = 1'b0;
      @(negedge clock);
      check_eq("mr_busy", 64'(bus.busy), 64'd0);
      check_eq("mr_ready", 64'(bus.load_ready), 64'd0);
      check_eq("mr_wc", 64'(bus.word_count), 64'd0);
      check_eq("mr_iv", 64'(bus.instr_valid), 64'd0);
      reset_n = 1'b1;
      @(negedge clock);
      check_eq("mr_idle", 64'(bus.busy), 64'd0);
      fetch_chk(0, "mr_pc0");
      fetch_chk(1, "mr_pc1");
      fetch_chk(2, "mr_pc2");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1);
   end

endmodule
